frame_buffer_swap_controller: RTL and testbench

- Parametrised successor to the two-buffer swap controller between the image buffer writer and the image buffer reader.
- Manages N_BUF SRAM frame buffers, each tracked as FREE, WRITING, READY or DISPLAY.
- Issues writer start/done handshakes, services reader swap requests, and publishes per-side buffer base addresses to the SRAM address generators.
- Two policies: LATEST (frame-drop, lowest latency) and FIFO (no drop, writer back-pressure).

---
 rtl/fbsc_pkg.sv | 33 +++
 rtl/fbsc_ready_queue.sv | 70 +++++++
 rtl/frame_buffer_swap_controller.sv | 191 +++++++++++++++++++
 tb/tb_frame_buffer_swap_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbsc_pkg.sv
// Shared types, FSM encodings and helpers for the frame buffer swap controller.
// Imported by the ready queue and the top level.
package fbsc_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        DISPLAY = 2'd3
    } buf_state_t;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_START = 2'd1;
    localparam logic [1:0] W_RUN   = 2'd2;
    localparam logic [1:0] W_ACK   = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_ACK  = 1'b1;

    localparam int MODE_LATEST = 0;
    localparam int MODE_FIFO   = 1;

    // Index width that never collapses to zero bits, so N_BUF=2 still gets one bit.
    function automatic int fbsc_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fbsc_ready_queue.sv
// Ordered queue of READY buffer indices. A push in the same cycle as a pop on an
// empty (or flushed) queue is forwarded straight to head so a finished frame can be shown at once.
module fbsc_ready_queue
    import fbsc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             pop,
    input  logic             flush,
    output logic [IDX_W-1:0] head,
    output logic [IDX_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = fbsc_clog2(DEPTH);

    logic [IDX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             bypass;
    logic             store;
    logic             pop_mem;
    logic [PTR_W-1:0] store_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == IDX_W'(DEPTH));
    assign bypass    = push && (empty || flush);
    assign head      = bypass ? push_idx : mem[rd_ptr];
    assign store     = push && !(pop && bypass);
    assign pop_mem   = pop && !empty && !flush;
    assign store_ptr = flush ? '0 : wr_ptr;

    always_ff @(posedge clock) begin
        if (store) begin
            mem[store_ptr] <= push_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Older entries are discarded; only a surviving push remains.
            rd_ptr <= '0;
            wr_ptr <= store ? next_ptr('0) : '0;
            count  <= IDX_W'(store);
        end else begin
            if (store) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_mem) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + IDX_W'(store) - IDX_W'(pop_mem);
        end
    end

endmodule

// File: rtl/frame_buffer_swap_controller.sv
// N-buffer frame swap controller between the image buffer writer and reader.
// Tracks per-buffer state, runs the writer and reader handshakes, and publishes base addresses.
module frame_buffer_swap_controller
    import fbsc_pkg::*;
#(
    parameter int N_BUF      = 3,
    parameter int ADDR_W     = 18,
    parameter int BUF_STRIDE = 32'h20000 >> (N_BUF > 2),
    parameter int MODE       = 0,
    parameter int CNT_W      = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         bg_start,
    input  logic                         bg_start_ack,
    input  logic                         bg_done,
    output logic                         bg_done_ack,
    input  logic                         swap,
    output logic                         swap_ack,
    output logic [ADDR_W-1:0]            wr_base,
    output logic [ADDR_W-1:0]            rd_base,
    output logic [fbsc_clog2(N_BUF)-1:0] wr_idx,
    output logic [fbsc_clog2(N_BUF)-1:0] rd_idx,
    output logic [CNT_W-1:0]             frame_count,
    output logic [CNT_W-1:0]             drop_count,
    output logic                         writer_stall
);

    localparam int IDX_W   = fbsc_clog2(N_BUF);
    localparam int Q_DEPTH = N_BUF - 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BUF_STRIDE);

    function automatic logic [ADDR_W-1:0] base_of(input logic [IDX_W-1:0] idx);
        return ADDR_W'(idx) * STRIDE;
    endfunction

    buf_state_t       bstate     [N_BUF];
    buf_state_t       bstate_nxt [N_BUF];
    logic [1:0]       w_state;
    logic [0:0]       r_state;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             claim;
    logic             do_done;
    logic             do_pop;
    logic             flush;

    logic [IDX_W-1:0] q_head;
    logic [IDX_W-1:0] q_count;
    logic             q_empty;
    logic             q_full;

    // Lowest-index FREE buffer, judged on registered state so a buffer freed this cycle waits one cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_BUF - 1; i >= 0; i--) begin
            if (bstate[i] == FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign claim   = (w_state == W_IDLE) && free_found && !((MODE == MODE_FIFO) && q_full);
    assign do_done = (w_state == W_RUN) && bg_done;
    assign flush   = do_done && (MODE == MODE_LATEST);
    assign do_pop  = (r_state == R_IDLE) && swap && (!q_empty || do_done);

    // Later assignments win: the done push lands before the swap pop claims the buffer.
    always_comb begin
        for (int i = 0; i < N_BUF; i++) begin
            bstate_nxt[i] = bstate[i];
            if (claim && (free_idx == IDX_W'(i))) begin
                bstate_nxt[i] = WRITING;
            end
            if (flush && (bstate[i] == READY)) begin
                bstate_nxt[i] = FREE;
            end
            if (do_done && (wr_idx == IDX_W'(i))) begin
                bstate_nxt[i] = READY;
            end
            if (do_pop && (rd_idx == IDX_W'(i))) begin
                bstate_nxt[i] = FREE;
            end
            if (do_pop && (q_head == IDX_W'(i))) begin
                bstate_nxt[i] = DISPLAY;
            end
        end
    end

    fbsc_ready_queue #(
        .DEPTH (Q_DEPTH),
        .IDX_W (IDX_W)
    ) u_ready_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (do_done),
        .push_idx (wr_idx),
        .pop      (do_pop),
        .flush    (flush),
        .head     (q_head),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < N_BUF; i++) begin
                bstate[i] <= (i == 0) ? DISPLAY : FREE;
            end
            w_state      <= W_IDLE;
            r_state      <= R_IDLE;
            wr_idx       <= IDX_W'(1);
            wr_base      <= STRIDE;
            rd_idx       <= '0;
            rd_base      <= '0;
            bg_start     <= 1'b0;
            bg_done_ack  <= 1'b0;
            swap_ack     <= 1'b0;
            writer_stall <= 1'b0;
            frame_count  <= '0;
            drop_count   <= '0;
        end else begin
            for (int i = 0; i < N_BUF; i++) begin
                bstate[i] <= bstate_nxt[i];
            end
            writer_stall <= 1'b0;

            case (w_state)
                W_IDLE: begin
                    if (claim) begin
                        wr_idx   <= free_idx;
                        wr_base  <= base_of(free_idx);
                        bg_start <= 1'b1;
                        w_state  <= W_START;
                    end else begin
                        writer_stall <= 1'b1;
                    end
                end
                W_START: begin
                    if (bg_start_ack) begin
                        bg_start <= 1'b0;
                        w_state  <= W_RUN;
                    end
                end
                W_RUN: begin
                    if (bg_done) begin
                        frame_count <= frame_count + CNT_W'(1);
                        bg_done_ack <= 1'b1;
                        w_state     <= W_ACK;
                        // Every queued entry is a READY frame that will never be shown.
                        if (flush) begin
                            drop_count <= drop_count + CNT_W'(q_count);
                        end
                    end
                end
                W_ACK: begin
                    if (!bg_done) begin
                        bg_done_ack <= 1'b0;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase

            case (r_state)
                R_IDLE: begin
                    if (swap) begin
                        swap_ack <= 1'b1;
                        r_state  <= R_ACK;
                        if (do_pop) begin
                            rd_idx  <= q_head;
                            rd_base <= base_of(q_head);
                        end
                    end
                end
                R_ACK: begin
                    if (!swap) begin
                        swap_ack <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_swap_controller.sv
// Bench for frame_buffer_swap_controller: a LATEST and a FIFO instance, directed handshakes,
// expected display index and frame count queued at issue time and checked when the acks rise.
module tb_frame_buffer_swap_controller;

    typedef struct {
        int d;
        int v;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset        [2];
    logic        bg_start     [2];
    logic        bg_start_ack [2];
    logic        bg_done      [2];
    logic        bg_done_ack  [2];
    logic        swap         [2];
    logic        swap_ack     [2];
    logic        writer_stall [2];
    logic [17:0] wr_base      [2];
    logic [17:0] rd_base      [2];
    logic [1:0]  wr_idx       [2];
    logic [1:0]  rd_idx       [2];
    logic [7:0]  frame_count  [2];
    logic [7:0]  drop_count   [2];

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_rd [$];
    exp_t exp_fc [$];
    exp_t mon_e;
    int   exp_fc_cnt [2] = '{0, 0};
    logic sa_q [2] = '{1'b0, 1'b0};
    logic da_q [2] = '{1'b0, 1'b0};
    logic watch_stall = 1'b0;
    logic stall_seen  = 1'b0;

    always #5 clock = ~clock;

    frame_buffer_swap_controller #(
        .N_BUF (3), .ADDR_W (18), .MODE (0), .CNT_W (8)
    ) u_latest (
        .clock        (clock),
        .reset        (reset[0]),
        .bg_start     (bg_start[0]),
        .bg_start_ack (bg_start_ack[0]),
        .bg_done      (bg_done[0]),
        .bg_done_ack  (bg_done_ack[0]),
        .swap         (swap[0]),
        .swap_ack     (swap_ack[0]),
        .wr_base      (wr_base[0]),
        .rd_base      (rd_base[0]),
        .wr_idx       (wr_idx[0]),
        .rd_idx       (rd_idx[0]),
        .frame_count  (frame_count[0]),
        .drop_count   (drop_count[0]),
        .writer_stall (writer_stall[0])
    );

    frame_buffer_swap_controller #(
        .N_BUF (3), .ADDR_W (18), .MODE (1), .CNT_W (8)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset[1]),
        .bg_start     (bg_start[1]),
        .bg_start_ack (bg_start_ack[1]),
        .bg_done      (bg_done[1]),
        .bg_done_ack  (bg_done_ack[1]),
        .swap         (swap[1]),
        .swap_ack     (swap_ack[1]),
        .wr_base      (wr_base[1]),
        .rd_base      (rd_base[1]),
        .wr_idx       (wr_idx[1]),
        .rd_idx       (rd_idx[1]),
        .frame_count  (frame_count[1]),
        .drop_count   (drop_count[1]),
        .writer_stall (writer_stall[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever an acknowledge rises.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (swap_ack[d] && !sa_q[d]) begin
                if (exp_rd.size() == 0) begin
                    chk("swap_ack_unexpected", d, -1);
                end else begin
                    mon_e = exp_rd.pop_front();
                    chk("swap_dut", d, mon_e.d);
                    chk("rd_idx", int'(rd_idx[d]), mon_e.v);
                    chk("rd_base", int'(rd_base[d]), mon_e.v * 32'h10000);
                end
            end
            if (bg_done_ack[d] && !da_q[d]) begin
                if (exp_fc.size() == 0) begin
                    chk("done_ack_unexpected", d, -1);
                end else begin
                    mon_e = exp_fc.pop_front();
                    chk("done_dut", d, mon_e.d);
                    chk("frame_count", int'(frame_count[d]), mon_e.v);
                end
            end
            sa_q[d] = swap_ack[d];
            da_q[d] = bg_done_ack[d];
        end
        if (watch_stall && writer_stall[0]) stall_seen = 1'b1;
    end

    function automatic logic out_sel(input int d, input int sel);
        case (sel)
            0:       return bg_start[d];
            1:       return bg_done_ack[d];
            default: return swap_ack[d];
        endcase
    endfunction

    task automatic wait_out(input int d, input int sel, input logic lvl, input string name);
        int n;
        n = 0;
        while (out_sel(d, sel) !== lvl && n < 40) begin
            @(negedge clock);
            n = n + 1;
        end
        if (out_sel(d, sel) !== lvl) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_reset_state(input int d);
        chk("rst_rd_idx", int'(rd_idx[d]), 0);
        chk("rst_wr_idx", int'(wr_idx[d]), 1);
        chk("rst_rd_base", int'(rd_base[d]), 0);
        chk("rst_wr_base", int'(wr_base[d]), 32'h10000);
        chk("rst_bg_start", int'(bg_start[d]), 0);
        chk("rst_bg_done_ack", int'(bg_done_ack[d]), 0);
        chk("rst_swap_ack", int'(swap_ack[d]), 0);
        chk("rst_writer_stall", int'(writer_stall[d]), 0);
        chk("rst_frame_count", int'(frame_count[d]), 0);
        chk("rst_drop_count", int'(drop_count[d]), 0);
    endtask

    task automatic start_handshake(input int d, input int exp_idx);
        wait_out(d, 0, 1'b1, "bg_start_rise");
        chk("wr_idx", int'(wr_idx[d]), exp_idx);
        chk("wr_base", int'(wr_base[d]), exp_idx * 32'h10000);
        bg_start_ack[d] = 1'b1;
        @(negedge clock);
        wait_out(d, 0, 1'b0, "bg_start_fall");
        bg_start_ack[d] = 1'b0;
    endtask

    task automatic finish_frame(input int d);
        exp_fc_cnt[d] = exp_fc_cnt[d] + 1;
        exp_fc.push_back('{d, exp_fc_cnt[d]});
        bg_done[d] = 1'b1;
        @(negedge clock);
        wait_out(d, 1, 1'b1, "done_ack_rise");
        bg_done[d] = 1'b0;
        wait_out(d, 1, 1'b0, "done_ack_fall");
    endtask

    task automatic write_frame(input int d, input int exp_idx);
        start_handshake(d, exp_idx);
        finish_frame(d);
    endtask

    task automatic do_swap(input int d, input int exp_idx);
        exp_rd.push_back('{d, exp_idx});
        swap[d] = 1'b1;
        @(negedge clock);
        chk("swap_ack_latency", int'(swap_ack[d]), 1);
        swap[d] = 1'b0;
        wait_out(d, 2, 1'b0, "swap_ack_fall");
    endtask

    task automatic done_and_swap(input int d, input int exp_idx);
        exp_fc_cnt[d] = exp_fc_cnt[d] + 1;
        exp_fc.push_back('{d, exp_fc_cnt[d]});
        exp_rd.push_back('{d, exp_idx});
        bg_done[d] = 1'b1;
        swap[d]    = 1'b1;
        @(negedge clock);
        chk("both_done_ack", int'(bg_done_ack[d]), 1);
        chk("both_swap_ack", int'(swap_ack[d]), 1);
        bg_done[d] = 1'b0;
        swap[d]    = 1'b0;
        wait_out(d, 1, 1'b0, "both_done_fall");
        wait_out(d, 2, 1'b0, "both_swap_fall");
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d]        = 1'b0;
            bg_start_ack[d] = 1'b0;
            bg_done[d]      = 1'b0;
            swap[d]         = 1'b0;
        end
        repeat (3) @(negedge clock);
        check_reset_state(0);
        check_reset_state(1);

        reset[0] = 1'b1;
        reset[1] = 1'b1;
        @(negedge clock);
        chk("rel_wr_idx", int'(wr_idx[0]), 1);
        chk("rel_wr_base", int'(wr_base[0]), 32'h10000);
        chk("rel_rd_base", int'(rd_base[0]), 0);
        @(negedge clock);
        chk("rel_bg_start", int'(bg_start[0]), 1);

        // LATEST: one frame then a swap that displays it and frees buffer 0.
        write_frame(0, 1);
        do_swap(0, 1);

        // LATEST: three frames without a swap drop two and never stall.
        watch_stall = 1'b1;
        write_frame(0, 2);
        write_frame(0, 0);
        write_frame(0, 2);
        chk("latest_drop_count", int'(drop_count[0]), 2);
        do_swap(0, 2);
        do_swap(0, 2);
        watch_stall = 1'b0;
        chk("latest_no_stall", int'(stall_seen), 0);

        // Done and swap together: the just-finished buffer is displayed.
        start_handshake(0, 0);
        done_and_swap(0, 0);
        chk("latest_drop_after_both", int'(drop_count[0]), 2);

        // Reset while the writer is mid-frame.
        start_handshake(0, 1);
        reset[0] = 1'b0;
        @(negedge clock);
        check_reset_state(0);
        repeat (2) @(negedge clock);
        reset[0] = 1'b1;
        exp_fc_cnt[0] = 0;
        write_frame(0, 1);

        // FIFO: two frames fill the queue and the writer stalls.
        write_frame(1, 1);
        write_frame(1, 2);
        repeat (3) @(negedge clock);
        chk("fifo_writer_stall", int'(writer_stall[1]), 1);
        chk("fifo_bg_start_low", int'(bg_start[1]), 0);
        do_swap(1, 1);
        write_frame(1, 0);
        do_swap(1, 2);
        do_swap(1, 0);
        chk("fifo_drop_count", int'(drop_count[1]), 0);
        chk("fifo_frame_count", int'(frame_count[1]), 3);

        repeat (2) @(negedge clock);
        chk("exp_rd_left", exp_rd.size(), 0);
        chk("exp_fc_left", exp_fc.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
